// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller:
// FSM states, opcodes, ALU select values and immediate formats.
package ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLTU = 3'b100
    } alu_op_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct fields into the ALU select and a
// legality flag for the supported instruction subset.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_t    alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        legal    = 1'b1;
                        alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                    end
                    3'b111: begin
                        legal    = !funct7_5;
                        alu_ctrl = ALU_AND;
                    end
                    3'b110: begin
                        legal    = !funct7_5;
                        alu_ctrl = ALU_OR;
                    end
                    3'b011: begin
                        legal    = !funct7_5;
                        alu_ctrl = ALU_SLTU;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM:             legal = (funct3 == 3'b000);
            OP_LOAD, OP_STORE:  legal = (funct3 == 3'b010);
            OP_BRANCH: begin
                legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
                alu_ctrl = ALU_SUB;
            end
            default:            legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// holds the instruction register, counts retired instructions, traps illegal ops.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      instr,
    input  logic                 eq,
    input  logic                 mem_stall,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic                 pc_src,
    output logic [2:0]           alu_ctrl,
    output logic                 alu_src,
    output logic [1:0]           imm_src,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic                 result_src,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    state_t          state, state_d;
    logic [XLEN-1:0] ir;
    alu_op_t         dec_op;
    logic            dec_legal;
    logic            is_lw, is_sw, is_addi, is_br;
    logic            unused_ir_bits;

    alu_decoder u_alu_decoder (
        .opcode   (ir[6:0]),
        .funct3   (ir[14:12]),
        .funct7_5 (ir[30]),
        .alu_ctrl (dec_op),
        .legal    (dec_legal)
    );

    assign is_lw   = (ir[6:0] == OP_LOAD);
    assign is_sw   = (ir[6:0] == OP_STORE);
    assign is_addi = (ir[6:0] == OP_IMM);
    assign is_br   = (ir[6:0] == OP_BRANCH);

    // Register-number and immediate fields are consumed by the datapath, not here.
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    always_comb begin
        state_d    = state;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        alu_ctrl   = 3'b000;
        alu_src    = 1'b0;
        imm_src    = IMM_I;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        result_src = 1'b0;
        illegal    = 1'b0;

        // ALU controls stay stable from EXEC through the end of the instruction.
        if (state == EXEC || state == MEM || state == WB) begin
            alu_ctrl = dec_op;
            alu_src  = is_addi || is_lw || is_sw;
            imm_src  = is_sw ? IMM_S : (is_br ? IMM_B : IMM_I);
        end

        case (state)
            FETCH: begin
                if (!mem_stall) begin
                    ir_en   = rst_n;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = dec_legal ? EXEC : TRAP;
            EXEC: begin
                if (is_br) begin
                    pc_en   = 1'b1;
                    pc_src  = ir[12] ? !eq : eq;
                    state_d = FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_write = is_sw;
                if (!mem_stall) begin
                    if (is_sw) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                result_src = is_lw;
                pc_en      = 1'b1;
                state_d    = FETCH;
            end
            TRAP:    illegal = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_d;
            if (ir_en) begin
                ir <= instr;
            end
            if (pc_en) begin
                retired <= retired + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: hand table of instruction vectors, random
// instruction stream against a per-instruction timing model, reset/trap/wrap cases.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        eq;
    logic        mem_stall;

    logic        ir_en, pc_en, pc_src, alu_src, reg_write, mem_write, result_src, illegal;
    logic [2:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic [31:0] retired;

    logic        d4_ir_en, d4_pc_en, d4_pc_src, d4_alu_src, d4_reg_write, d4_mem_write;
    logic        d4_result_src, d4_illegal;
    logic [2:0]  d4_alu_ctrl;
    logic [1:0]  d4_imm_src;
    logic [3:0]  d4_retired;

    logic [12:0] obs, obs4;
    logic [31:0] cnt;
    int          total, bad;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .eq(eq), .mem_stall(mem_stall),
        .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
        .alu_src(alu_src), .imm_src(imm_src), .reg_write(reg_write),
        .mem_write(mem_write), .result_src(result_src), .illegal(illegal),
        .retired(retired)
    );

    multicycle_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .eq(eq), .mem_stall(mem_stall),
        .ir_en(d4_ir_en), .pc_en(d4_pc_en), .pc_src(d4_pc_src), .alu_ctrl(d4_alu_ctrl),
        .alu_src(d4_alu_src), .imm_src(d4_imm_src), .reg_write(d4_reg_write),
        .mem_write(d4_mem_write), .result_src(d4_result_src), .illegal(d4_illegal),
        .retired(d4_retired)
    );

    assign obs  = {ir_en, pc_en, pc_src, alu_ctrl, alu_src, imm_src,
                   reg_write, mem_write, result_src, illegal};
    assign obs4 = {d4_ir_en, d4_pc_en, d4_pc_src, d4_alu_ctrl, d4_alu_src, d4_imm_src,
                   d4_reg_write, d4_mem_write, d4_result_src, d4_illegal};

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        eq;
        int          fstall;
        int          mstall;
        int          cycles;
        logic [2:0]  alu;
        logic        asrc;
        logic [1:0]  imm;
        logic        rw;
        logic        mw;
        logic        rs;
        logic        pcs;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mkv(string nm, logic [31:0] w, logic e, int fs, int ms, int cyc,
                                 logic [2:0] alu, logic asrc, logic [1:0] imm,
                                 logic rw, logic mw, logic rs, logic pcs);
        vec_t v;
        v.name = nm; v.instr = w; v.eq = e; v.fstall = fs; v.mstall = ms; v.cycles = cyc;
        v.alu = alu; v.asrc = asrc; v.imm = imm; v.rw = rw; v.mw = mw; v.rs = rs; v.pcs = pcs;
        return v;
    endfunction

    function automatic logic [12:0] mk(logic ire, logic pce, logic pcs, logic [5:0] af,
                                       logic rw, logic mw, logic rs, logic ill);
        return {ire, pce, pcs, af, rw, mw, rs, ill};
    endfunction

    // Expected instruction behaviour derived from the ISA-level rules.
    function automatic vec_t model(logic [31:0] w, logic e, int fs, int ms);
        vec_t v;
        logic [2:0] f3;
        f3 = w[14:12];
        v = mkv("rnd", w, e, fs, ms, 4, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        case (w[6:0])
            7'b0110011: begin
                if (f3 == 3'b000)      v.alu = w[30] ? 3'b001 : 3'b000;
                else if (f3 == 3'b111) v.alu = 3'b010;
                else if (f3 == 3'b110) v.alu = 3'b011;
                else                   v.alu = 3'b100;
            end
            7'b0010011: v.asrc = 1'b1;
            7'b0000011: begin v.asrc = 1'b1; v.cycles = 5; v.rs = 1'b1; end
            7'b0100011: begin v.asrc = 1'b1; v.imm = 2'b01; v.rw = 1'b0; v.mw = 1'b1; end
            default: begin
                v.cycles = 3; v.alu = 3'b001; v.imm = 2'b10; v.rw = 1'b0;
                v.pcs = (f3 == 3'b000) ? e : !e;
            end
        endcase
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        logic [31:0] w;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          k, fs, ms;
        w  = $urandom;
        k  = $urandom_range(0, 9);
        f7 = 7'h00;
        op = 7'b0110011;
        f3 = 3'b000;
        case (k)
            1: f7 = 7'h20;
            2: f3 = 3'b111;
            3: f3 = 3'b110;
            4: f3 = 3'b011;
            5: op = 7'b0010011;
            6: begin op = 7'b0000011; f3 = 3'b010; end
            7: begin op = 7'b0100011; f3 = 3'b010; end
            8: op = 7'b1100011;
            9: begin op = 7'b1100011; f3 = 3'b001; end
            default: f3 = 3'b000;
        endcase
        w[6:0]   = op;
        w[14:12] = f3;
        if (op == 7'b0110011) w[31:25] = f7;
        fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        ms = $urandom_range(0, 3);
        return model(w, 1'($urandom_range(0, 1)), fs, ms);
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic [31:0] i, input logic s, input logic e,
                       input logic [12:0] ex, input string nm, input bit ret);
        @(negedge clk);
        instr = i; mem_stall = s; eq = e;
        #1;
        check(nm, 64'({obs, obs4}), 64'({ex, ex}));
        check({nm, "/ret"}, 64'({retired, d4_retired}), 64'({cnt, cnt[3:0]}));
        if (ret) cnt = cnt + 32'd1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run(input vec_t v);
        logic [5:0] af;
        logic       last, has_mem;
        af      = {v.alu, v.asrc, v.imm};
        last    = (v.cycles == 3);
        has_mem = (v.cycles == 5) || v.mw;
        for (int k = 0; k < v.fstall; k++)
            cyc($urandom, 1'b1, rb(), 13'd0, {v.name, "/fstall"}, 1'b0);
        cyc(v.instr, 1'b0, rb(), mk(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0),
            {v.name, "/fetch"}, 1'b0);
        cyc($urandom, rb(), rb(), 13'd0, {v.name, "/decode"}, 1'b0);
        cyc($urandom, rb(), v.eq, mk(1'b0, last, last & v.pcs, af, 1'b0, 1'b0, 1'b0, 1'b0),
            {v.name, "/exec"}, last);
        if (has_mem) begin
            for (int k = 0; k < v.mstall; k++)
                cyc($urandom, 1'b1, rb(), mk(1'b0, 1'b0, 1'b0, af, 1'b0, v.mw, 1'b0, 1'b0),
                    {v.name, "/mstall"}, 1'b0);
            cyc($urandom, 1'b0, rb(), mk(1'b0, v.mw, 1'b0, af, 1'b0, v.mw, 1'b0, 1'b0),
                {v.name, "/mem"}, v.mw);
        end
        if (v.rw)
            cyc($urandom, rb(), rb(), mk(1'b0, 1'b1, 1'b0, af, 1'b1, 1'b0, v.rs, 1'b0),
                {v.name, "/wb"}, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_stall = 1'b0;
        #1;
        cnt = 32'd0;
        check("reset_outs", 64'({obs, obs4}), 64'd0);
        check("reset_ret", 64'({retired, d4_retired}), 64'd0);
        mem_stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; cnt = 32'd0;
        rst_n = 1'b0; instr = 32'd0; eq = 1'b0; mem_stall = 1'b1;

        tbl[0]  = mkv("add",  32'h002081B3, 1'b0, 0, 0, 4, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mkv("sub",  32'h402081B3, 1'b1, 0, 0, 4, 3'b001, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mkv("addi", 32'h00500093, 1'b0, 0, 0, 4, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mkv("lw",   32'h0040A103, 1'b0, 0, 0, 5, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mkv("sw_st",32'h0020A423, 1'b0, 0, 3, 4, 3'b000, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mkv("bne0", 32'hFE209CE3, 1'b0, 0, 0, 3, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mkv("bne1", 32'hFE209CE3, 1'b1, 0, 0, 3, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mkv("beq1", 32'hFE208CE3, 1'b1, 0, 0, 3, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[8]  = mkv("and",  32'h0020F1B3, 1'b0, 0, 0, 4, 3'b010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mkv("or",   32'h0020E1B3, 1'b0, 0, 0, 4, 3'b011, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[10] = mkv("sltu", 32'h0020B1B3, 1'b0, 1, 0, 4, 3'b100, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[11] = mkv("lw_st",32'h0040A103, 1'b0, 2, 2, 5, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        pulse_reset();

        foreach (tbl[i]) run(tbl[i]);

        for (int n = 0; n < 300; n++) run(rnd_vec());

        // Reset asserted while an add sits in EXEC: it must not retire.
        cyc(32'h002081B3, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0),
            "rx/fetch", 1'b0);
        cyc($urandom, 1'b0, 1'b0, 13'd0, "rx/decode", 1'b0);
        pulse_reset();
        run(tbl[0]);

        pulse_reset();
        for (int n = 0; n < 16; n++) run(tbl[2]);
        @(negedge clk);
        mem_stall = 1'b1;
        #1;
        check("wrap4", 64'(d4_retired), 64'd0);
        check("wrap32", 64'(retired), 64'd16);

        // Illegal opcode: trap is sticky and freezes every strobe.
        cyc(32'h00000000, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0),
            "trap/fetch", 1'b0);
        cyc($urandom, 1'b0, 1'b0, 13'd0, "trap/decode", 1'b0);
        for (int n = 0; n < 100; n++)
            cyc($urandom, rb(), rb(), mk(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1),
                "trap/hold", 1'b0);
        pulse_reset();
        run(tbl[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
